// File: rtl/delay_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : delay_timer_arbiter
// Brief    : Round-robin shared prescaled delay timer; one delay per grant,
//            finished by a one-cycle done pulse. Optional DELAY_TIMER_ABORT_EN
//            aborts a delay when the granted request drops while counting.
// Revision : 1.0 - initial release
// ============================================================================
module delay_timer_arbiter #(
    parameter int NREQ     = 4,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] delay,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  tick
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int PRE_W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [NREQ-1:0]   grant_next;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  last_next;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [CNT_W-1:0]  pick_delay;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  rem_next;
    logic [PRE_W-1:0]  pre;
    logic [PRE_W-1:0]  pre_next;
    logic              abort;

    // Walk downward so the last hit is the index closest after 'last'.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(last) + i) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(last) + i) % NREQ);
            end
        end
    end

    assign pick_delay = delay[int'(pick_idx)*CNT_W +: CNT_W];

    assign tick = (state == COUNT) && (pre == PRE_MAX);
    assign busy = (state != IDLE);
    assign done = (state == DONE) ? grant : '0;

`ifdef DELAY_TIMER_ABORT_EN
    assign abort = (state == COUNT) && ((req & grant) == '0);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        rem_next   = rem;
        pre_next   = pre;
        case (state)
            IDLE: begin
                pre_next = '0;
                if (pick_valid) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    last_next            = pick_idx;
                    rem_next             = pick_delay;
                    state_next           = (pick_delay == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    // last already holds the aborted client
                    state_next = IDLE;
                    grant_next = '0;
                    pre_next   = '0;
                end else if (tick) begin
                    pre_next = '0;
                    if (rem <= CNT_W'(1)) begin
                        state_next = DONE;
                    end else begin
                        rem_next = rem - CNT_W'(1);
                    end
                end else begin
                    pre_next = pre + PRE_W'(1);
                end
            end
            DONE: begin
                grant_next = '0;
                state_next = IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            last  <= LAST_RST;
            rem   <= '0;
            pre   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
            rem   <= rem_next;
            pre   <= pre_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_timer_arbiter.sv
`default_nettype none
// Directed bench for delay_timer_arbiter: PRESCALE=1 instance for most
// scenarios, PRESCALE=0 instance for the maximum-delay case.
module tb_delay_timer_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] delay;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        tick;

    logic [3:0]  req_b;
    logic [31:0] delay_b;
    logic [3:0]  grant_b;
    logic [3:0]  done_b;
    logic        busy_b;
    logic        tick_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    delay_timer_arbiter #(.NREQ(4), .CNT_W(8), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .req(req), .delay(delay),
        .grant(grant), .done(done), .busy(busy), .tick(tick)
    );

    delay_timer_arbiter #(.NREQ(4), .CNT_W(8), .PRESCALE(0)) dut0 (
        .clk(clk), .reset(reset), .req(req_b), .delay(delay_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .tick(tick_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        req     = '0;
        delay   = '0;
        req_b   = '0;
        delay_b = '0;
        cyc(2);
        chk("rst_grant", grant, 0);
        chk("rst_done",  done,  0);
        chk("rst_busy",  busy,  0);
        chk("rst_tick",  tick,  0);
        reset = 1'b1;

        // Single delay: delay0=3, sampled in cycle 0
        req   = 4'b0001;
        delay = {8'd0, 8'd0, 8'd0, 8'd3};
        cyc(1);
        chk("sd_c1_grant", grant, 4'b0001);
        chk("sd_c1_busy",  busy,  1);
        chk("sd_c1_tick",  tick,  0);
        cyc(1);
        chk("sd_c2_tick",  tick,  1);
        cyc(1);
        chk("sd_c3_tick",  tick,  0);
        cyc(1);
        chk("sd_c4_tick",  tick,  1);
        cyc(2);
        chk("sd_c6_tick",  tick,  1);
        chk("sd_c6_done",  done,  0);
        cyc(1);
        chk("sd_c7_done",  done,  4'b0001);
        chk("sd_c7_grant", grant, 4'b0001);
        chk("sd_c7_tick",  tick,  0);
        req = '0;
        cyc(1);
        chk("sd_c8_grant", grant, 0);
        chk("sd_c8_busy",  busy,  0);
        chk("sd_c8_done",  done,  0);

        // Zero delay on client 2
        req   = 4'b0100;
        delay = '0;
        cyc(1);
        chk("zd_grant", grant, 4'b0100);
        chk("zd_done",  done,  4'b0100);
        chk("zd_tick",  tick,  0);
        req = '0;
        cyc(1);
        chk("zd_idle_busy",  busy,  0);
        chk("zd_idle_grant", grant, 0);

        // Round-robin from reset with all requests held, all delays 1
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        req   = 4'b1111;
        delay = {4{8'd1}};
        begin
            logic [3:0] seq [5];
            seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
            seq[3] = 4'b1000; seq[4] = 4'b0001;
            for (int k = 0; k < 5; k++) begin
                cyc(1);
                chk($sformatf("rr%0d_grant", k), grant, seq[k]);
                cyc(2);
                chk($sformatf("rr%0d_done", k), done, seq[k]);
                cyc(1);
                chk($sformatf("rr%0d_idle", k), busy, 0);
            end
        end
        req = '0;
        cyc(1);
        chk("rr_end_busy", busy, 0);

        // Reset mid-delay, then priority restarts at index 0
        req   = 4'b0001;
        delay = {8'd0, 8'd0, 8'd0, 8'd5};
        cyc(3);
        chk("rm_c3_busy", busy, 1);
        reset = 1'b0;
        cyc(1);
        chk("rm_grant", grant, 0);
        chk("rm_done",  done,  0);
        chk("rm_busy",  busy,  0);
        reset = 1'b1;
        req   = 4'b1001;
        cyc(1);
        chk("rm_regrant", grant, 4'b0001);
        cyc(9);
        chk("rm_nodone_early", done, 0);
        cyc(1);
        chk("rm_done0", done, 4'b0001);
        req   = 4'b1000;
        delay = '0;
        cyc(1);
        chk("rm_idle", busy, 0);
        cyc(1);
        chk("rm_grant3", grant, 4'b1000);
        chk("rm_done3",  done,  4'b1000);
        req = '0;
        cyc(1);

        // Dropped request on client 2 during COUNT
        req   = 4'b0100;
        delay = {8'd0, 8'd10, 8'd0, 8'd0};
        cyc(3);
        chk("ab_c3_grant", grant, 4'b0100);
        req = '0;
        cyc(1);
`ifdef DELAY_TIMER_ABORT_EN
        chk("ab_c4_grant", grant, 0);
        chk("ab_c4_busy",  busy,  0);
`else
        chk("ab_c4_grant", grant, 4'b0100);
        chk("ab_c4_busy",  busy,  1);
`endif
        begin
            int early_done = 0;
            for (int c = 5; c <= 20; c++) begin
                cyc(1);
                if (done !== 4'b0000) early_done++;
            end
            chk("ab_no_early_done", early_done, 0);
        end
        cyc(1);
`ifdef DELAY_TIMER_ABORT_EN
        chk("ab_c21_done", done, 0);
`else
        chk("ab_c21_done", done, 4'b0100);
`endif
        cyc(1);
        chk("ab_c22_busy", busy, 0);

        // Maximum delay on the PRESCALE=0 instance
        req_b   = 4'b0001;
        delay_b = {8'd0, 8'd0, 8'd0, 8'd255};
        cyc(1);
        chk("mx_grant", grant_b, 4'b0001);
        chk("mx_tick",  tick_b,  1);
        cyc(254);
        chk("mx_255_done", done_b, 0);
        chk("mx_255_busy", busy_b, 1);
        cyc(1);
        chk("mx_256_done", done_b, 4'b0001);
        req_b = '0;
        cyc(1);
        chk("mx_257_busy", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Shared delay-timer controller. It owns one prescaled tick counter and one down-counter, and time-shares them between NREQ requesters using round-robin arbitration. Each granted requester gets exactly one delay of its programmed number of ticks, then receives a one-cycle done pulse. It sits between client state machines needing timed waits and the prescaler/counter datapath, so several clients can share one timer instead of each instantiating its own prescaled counter.

## Interface
- NREQ, 4, number of requesters (2..8)
- CNT_W, 8, width of each requester's delay value, in ticks
- PRESCALE, 1, tick period is PRESCALE+1 clk cycles; 0 means a tick every cycle

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- req  in  NREQ  request per client; held high until done (or abort)
- delay  in  NREQ*CNT_W  delay for client i in bits [i*CNT_W +: CNT_W]; sampled only at grant
- grant  out  NREQ  one-hot, registered; high from grant cycle through done cycle
- done  out  NREQ  one-cycle pulse to the granted client at end of delay
- busy  out  1  high whenever state is not IDLE
- tick  out  1  prescaler tick, valid only in COUNT

## Operation
- The FSM has three states: IDLE, COUNT and DONE.
- **IDLE**
  - If any req bit is set, pick the first set index searching from last+1 upward, wrapping modulo NREQ.
  - Register that index into grant, set last to it, and latch its delay into rem.
  - Clear pre.
  - Go to COUNT if the latched delay is nonzero; go to DONE if it is 0.
- **COUNT**
  - pre counts 0..PRESCALE and then wraps to 0.
  - tick = (pre == PRESCALE).
  - On a tick: if rem == 1, go to DONE; otherwise decrement rem.
  - req and delay changes are ignored in this state, except as described under Configuration.
- **DONE**
  - done = grant for one cycle; grant is still held.
  - Next cycle: grant is cleared and the FSM returns to IDLE.
- Arbitration happens only in IDLE. Back-to-back grants therefore have at least one IDLE cycle between them.
- rem is CNT_W bits wide and never underflows. pre is clog2(PRESCALE+1) bits wide, minimum 1.
- Reset (sampled low):
  - Next cycle: state=IDLE, grant=0, done=0, busy=0, tick=0, rem=0, pre=0, last=NREQ-1, so index 0 has first priority.
  - Reset mid-delay aborts the delay without a done pulse.

## Timing
- Let t be the IDLE cycle in which req is sampled.
- grant and busy go high at t+1.
- Ticks occur at t+k*(PRESCALE+1) for k = 1..D.
- done pulses at t+1+D*(PRESCALE+1).
- grant clears and the FSM is back in IDLE at t+2+D*(PRESCALE+1).
- D=0: done pulses at t+1, IDLE at t+2.
- Maximum delay is 2^CNT_W-1 ticks.
- Requests arriving during COUNT or DONE wait until the next IDLE cycle.
- A requester that keeps req high after its own done re-enters arbitration at lowest priority relative to the others.

## Configuration
- The macro DELAY_TIMER_ABORT_EN selects how a dropped request is handled during COUNT.
- **Defined**
  - If the granted client's req goes low during COUNT, the delay is aborted.
  - Next cycle: state=IDLE, grant=0, no done pulse, and last is updated to that client.
  - In DONE, req is ignored.
- **Undefined**
  - req is ignored once granted.
  - The delay always runs to completion and done is always pulsed.

## Test plan
All scenarios use NREQ=4, CNT_W=8, PRESCALE=1 unless stated otherwise.
- **Single delay:** reset released, req=0001, delay0=3 sampled at cycle 0 -> grant=0001 at cycle 1, tick at cycles 2/4/6, done=0001 at cycle 7 only, grant=0 and busy=0 at cycle 8.
- **Zero delay:** req=0100, delay2=0 at t -> grant=0100 and done=0100 at t+1, no tick, IDLE at t+2.
- **Round-robin:** req=1111 held, all delays 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with done pulses 4 cycles apart per grant, each followed by one IDLE cycle.
- **Reset mid-delay:** reset low at cycle 3 of a delay0=5 run -> next cycle grant=0, done=0, busy=0, no later done. After release with req=1001, grant=0001 first.
- **Abort:** req2 dropped at cycle 3 of delay2=10 -> with DELAY_TIMER_ABORT_EN, grant=0 next cycle and done[2] never pulses. Without it, done[2] pulses at t+21.
- **Max delay:** PRESCALE=0, delay0=255 -> done[0] at t+256, rem never wraps.
